des_decrypt_iter: RTL and testbench

DES_DECRYPT_ITER -- requirements
Module: des_decrypt_iter

---
 rtl/des_pkg.sv | 153 +++++++++++++++
 rtl/des_feistel_f.sv | 18 +
 rtl/des_decrypt_iter.sv | 167 ++++++++++++++++
 tb/tb_des_decrypt_iter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// des_pkg: DES permutation and S-box tables, key shift schedule, FSM state
// enum, and the helper functions that apply the tables.
// Table entries use DES numbering: 1-based, where bit 1 is the MSB.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
  };

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
  };

  // Standard 64-bit-key PC-1; the parity-free key mapping is done in pc1_perm.
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
  };

  // Encryption left-shift schedule, rounds 1..16.
  localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // S-boxes, each laid out row-major: index = row*16 + col.
  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
  };

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction

  // The key arrives with its parity bits already stripped, so a 64-bit
  // position p maps to parity-free position p - p/8.
  function automatic logic [55:0] pc1_perm(input logic [55:0] k);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[55-i] = k[56-(PC1_T[i] - PC1_T[i]/8)];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] cd);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = cd[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] s_sub(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  c;
    logic [31:0] v;
    y = '0;
    for (int b = 0; b < 8; b++) begin
      c = x[47-6*b -: 6];
      v = SBOX[b][{c[5], c[0], c[4:1]}];
      y[31-4*b -: 4] = v[3:0];
    end
    return y;
  endfunction

  function automatic logic [27:0] ror28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_feistel_f.sv
// des_feistel_f: combinational DES round function f(R, K) = P(S(E(R) ^ K)).
module des_feistel_f
  import des_pkg::*;
(
  input  logic [31:0] r_i,
  input  logic [47:0] k_i,
  output logic [31:0] f_o
);

  logic [47:0] x_s;

  // Expand and key-mix R, then substitute and permute.
  always_comb begin
    x_s = e_expand(r_i) ^ k_i;
    f_o = p_perm(s_sub(x_s));
  end

endmodule

// File: rtl/des_decrypt_iter.sv
// des_decrypt_iter: iterative DES decryptor, ROUNDS_PER_CYCLE rounds per clock.
// Optional CBC chaining is enabled by defining DES_DECRYPT_ITER_CBC_EN.
//
// state | meaning
// IDLE  | waiting for ct/key; in_ready high
// RUN   | Feistel rounds in progress
// DONE  | pt valid, held until out_ready
module des_decrypt_iter
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [55:0] key,
  input  logic [63:0] ct,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] pt,
  output logic        busy
`ifdef DES_DECRYPT_ITER_CBC_EN
  ,
  input  logic        iv_load,
  input  logic [63:0] iv
`endif
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rpc
    $error("des_decrypt_iter: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] l_q, r_q, l_d, r_d;
  logic [27:0] c_q, d_q, c_d, d_d;
  logic [63:0] pt_q, pt_d;
  logic [63:0] mask;
  logic        iv_blk;
  logic        accept;
  logic        last;

  assign accept = in_valid && in_ready;
  assign last   = (cnt_q == 4'(16 - ROUNDS_PER_CYCLE));

  // Unrolled decryption rounds; subkeys run K16..K1 by rotating C/D right.
  for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
    logic [31:0] l_in, r_in, l_out, r_out, f_val;
    logic [27:0] c_in, d_in, c_out, d_out;
    logic [3:0]  rnd;
    logic        two;

    if (j == 0) begin : g_src
      assign l_in = l_q;
      assign r_in = r_q;
      assign c_in = c_q;
      assign d_in = d_q;
    end else begin : g_src
      assign l_in = g_round[j-1].l_out;
      assign r_in = g_round[j-1].r_out;
      assign c_in = g_round[j-1].c_out;
      assign d_in = g_round[j-1].d_out;
    end

    des_feistel_f u_f (
      .r_i (r_in),
      .k_i (pc2_perm({c_in, d_in})),
      .f_o (f_val)
    );

    // 0-based decrypt round rnd undoes encryption round 16-rnd's shift.
    assign rnd   = cnt_q + 4'(j);
    assign two   = (SHIFT[15 - int'(rnd)] == 2);
    assign l_out = r_in;
    assign r_out = l_in ^ f_val;
    assign c_out = ror28(c_in, two);
    assign d_out = ror28(d_in, two);
  end

  assign l_d   = g_round[ROUNDS_PER_CYCLE-1].l_out;
  assign r_d   = g_round[ROUNDS_PER_CYCLE-1].r_out;
  assign c_d   = g_round[ROUNDS_PER_CYCLE-1].c_out;
  assign d_d   = g_round[ROUNDS_PER_CYCLE-1].d_out;
  assign cnt_d = cnt_q + 4'(ROUNDS_PER_CYCLE);
  assign pt_d  = fp_perm({r_d, l_d}) ^ mask;

`ifdef DES_DECRYPT_ITER_CBC_EN
  logic [63:0] chain_q;
  logic [63:0] mask_q;

  // chain holds the previous ct (or loaded IV); mask freezes it for the block in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_q <= '0;
      mask_q  <= '0;
    end else if (accept) begin
      chain_q <= ct;
      mask_q  <= chain_q;
    end else if (state_q == IDLE && iv_load) begin
      chain_q <= iv;
    end
  end

  assign mask   = mask_q;
  assign iv_blk = iv_load;
`else
  assign mask   = '0;
  assign iv_blk = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !iv_blk;
        if (in_valid && !iv_blk) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, iterate in RUN, capture pt on the final round.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      l_q   <= '0;
      r_q   <= '0;
      c_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
      pt_q  <= '0;
    end else if (accept) begin
      {l_q, r_q} <= ip_perm(ct);
      {c_q, d_q} <= pc1_perm(key);
      cnt_q      <= '0;
    end else if (state_q == RUN) begin
      l_q   <= l_d;
      r_q   <= r_d;
      c_q   <= c_d;
      d_q   <= d_d;
      cnt_q <= cnt_d;
      if (last) pt_q <= pt_d;
    end
  end

  assign pt = pt_q;

endmodule

// File: tb/tb_des_decrypt_iter.sv
// tb_des_decrypt_iter: directed-vector bench for des_decrypt_iter.
module tb_des_decrypt_iter;

  localparam int RPC = 1;
  localparam int LAT = 16 / RPC;

  localparam logic [55:0] K_STD  = 56'h12695BC9B7B7F8;
  localparam logic [63:0] C_STD  = 64'h85E813540F0AB405;
  localparam logic [63:0] P_STD  = 64'h0123456789ABCDEF;
  localparam logic [55:0] K_CMP  = 56'hED96A436484807;
  localparam logic [63:0] C_CMP  = 64'h7A17ECABF0F54BFA;
  localparam logic [63:0] P_CMP  = 64'hFEDCBA9876543210;
  localparam logic [55:0] K_ZERO = 56'h0;
  localparam logic [63:0] C_ZERO = 64'h8CA64DE9C1B123A7;
  localparam logic [63:0] P_ZERO = 64'h0;
  localparam logic [55:0] K_ONES = 56'hFFFFFFFFFFFFFF;
  localparam logic [63:0] C_ONES = 64'h7359B2163E4EDC58;
  localparam logic [63:0] P_ONES = 64'hFFFFFFFFFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [55:0] key;
  logic [63:0] ct, pt;
`ifdef DES_DECRYPT_ITER_CBC_EN
  logic        iv_load;
  logic [63:0] iv;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  des_decrypt_iter #(.ROUNDS_PER_CYCLE(RPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key       (key),
    .ct        (ct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt        (pt),
    .busy      (busy)
`ifdef DES_DECRYPT_ITER_CBC_EN
    ,
    .iv_load   (iv_load),
    .iv        (iv)
`endif
  );

  always #5 clk = ~clk;

  // Issue one block, scramble inputs after accept, wait (bounded) for out_valid.
  task automatic run_block(input logic [55:0] k, input logic [63:0] c, input bit clr_iv,
                           output logic [63:0] got, output int lat,
                           output logic busy_a, output logic rdy_a);
    if (clr_iv) begin
`ifdef DES_DECRYPT_ITER_CBC_EN
      iv = '0; iv_load = 1'b1;
      @(posedge clk); #1;
      iv_load = 1'b0;
`endif
    end
    key = k; ct = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; key = ~k; ct = ~c;
    busy_a = busy; rdy_a = in_ready;
    lat = -1; got = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; got = pt; break; end
    end
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; key = '0; ct = '0;
`ifdef DES_DECRYPT_ITER_CBC_EN
    iv_load = 1'b0; iv = '0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests_run++; if (pt !== 64'h0) begin tests_failed++; $display("FAIL reset_pt: got %h want 0", pt); end
    @(posedge clk); #1;
  endtask

  task automatic test_decrypt_zero;
    logic [63:0] got; int lat; logic b, r;
    run_block(K_ZERO, C_ZERO, 1'b1, got, lat, b, r);
    tests_run++; if (lat !== LAT) begin tests_failed++; $display("FAIL zero_latency: got %0d want %0d", lat, LAT); end
    tests_run++; if (got !== P_ZERO) begin tests_failed++; $display("FAIL zero_pt: got %h want %h", got, P_ZERO); end
    tests_run++; if (b !== 1'b1) begin tests_failed++; $display("FAIL run_busy: got %b want 1", b); end
    tests_run++; if (r !== 1'b0) begin tests_failed++; $display("FAIL run_in_ready: got %b want 0", r); end
    release_out();
  endtask

  task automatic test_decrypt_vectors;
    logic [55:0] kv [3];
    logic [63:0] cv [3];
    logic [63:0] pv [3];
    logic [63:0] got; int lat; logic b, r;
    kv[0] = K_STD;  cv[0] = C_STD;  pv[0] = P_STD;
    kv[1] = K_ONES; cv[1] = C_ONES; pv[1] = P_ONES;
    kv[2] = K_CMP;  cv[2] = C_CMP;  pv[2] = P_CMP;
    for (int v = 0; v < 3; v++) begin
      run_block(kv[v], cv[v], 1'b1, got, lat, b, r);
      tests_run++; if (lat !== LAT) begin tests_failed++; $display("FAIL vec%0d_latency: got %0d want %0d", v, lat, LAT); end
      tests_run++; if (got !== pv[v]) begin tests_failed++; $display("FAIL vec%0d_pt: got %h want %h", v, got, pv[v]); end
      release_out();
    end
  endtask

  task automatic test_hold_done;
    logic [63:0] got; int lat; logic b, r;
    run_block(K_CMP, C_CMP, 1'b1, got, lat, b, r);
    tests_run++; if (got !== P_CMP) begin tests_failed++; $display("FAIL hold_first_pt: got %h want %h", got, P_CMP); end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin key = K_ZERO; ct = C_ZERO; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL hold_out_valid[%0d]: got %b want 1", i, out_valid); end
      tests_run++; if (pt !== P_CMP) begin tests_failed++; $display("FAIL hold_pt[%0d]: got %h want %h", i, pt, P_CMP); end
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready); end
    end
    in_valid = 1'b0;
    release_out();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL release_out_valid: got %b want 0", out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL hold_pulse_accepted: busy %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int acc_edge [2];
    logic [63:0] got [2];
    int n_acc, n_out;
    logic acc_now;
    logic [63:0] exp2;
`ifdef DES_DECRYPT_ITER_CBC_EN
    iv = '0; iv_load = 1'b1;
    @(posedge clk); #1;
    iv_load = 1'b0;
    exp2 = P_ONES ^ C_STD;
`else
    exp2 = P_ONES;
`endif
    acc_edge[0] = -1; acc_edge[1] = -1; got[0] = '0; got[1] = '0;
    n_acc = 0; n_out = 0;
    key = K_STD; ct = C_STD; in_valid = 1'b1; out_ready = 1'b1;
    for (int e = 0; e < 80 && n_out < 2; e++) begin
      acc_now = in_ready && in_valid;
      @(posedge clk); #1;
      if (acc_now && n_acc < 2) begin
        acc_edge[n_acc] = e;
        n_acc++;
        if (n_acc == 1) begin key = K_ONES; ct = C_ONES; end
        else in_valid = 1'b0;
      end
      if (out_valid && n_out < 2) begin got[n_out] = pt; n_out++; end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tests_run++; if (acc_edge[1] - acc_edge[0] !== LAT + 2) begin tests_failed++; $display("FAIL b2b_interval: got %0d want %0d", acc_edge[1] - acc_edge[0], LAT + 2); end
    tests_run++; if (n_out !== 2) begin tests_failed++; $display("FAIL b2b_outputs: got %0d want 2", n_out); end
    tests_run++; if (got[0] !== P_STD) begin tests_failed++; $display("FAIL b2b_pt0: got %h want %h", got[0], P_STD); end
    tests_run++; if (got[1] !== exp2) begin tests_failed++; $display("FAIL b2b_pt1: got %h want %h", got[1], exp2); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [63:0] got; int lat; logic b, r;
    bit seen;
`ifdef DES_DECRYPT_ITER_CBC_EN
    iv = '0; iv_load = 1'b1;
    @(posedge clk); #1;
    iv_load = 1'b0;
`endif
    key = K_STD; ct = C_STD; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b want 0", busy); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    tests_run++; if (pt !== 64'h0) begin tests_failed++; $display("FAIL midrst_pt: got %h want 0", pt); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL midrst_abandoned: out_valid seen %b want 0", seen); end
    run_block(K_STD, C_STD, 1'b0, got, lat, b, r);
    tests_run++; if (lat !== LAT) begin tests_failed++; $display("FAIL midrst_next_latency: got %0d want %0d", lat, LAT); end
    tests_run++; if (got !== P_STD) begin tests_failed++; $display("FAIL midrst_next_pt: got %h want %h", got, P_STD); end
    release_out();
  endtask

`ifdef DES_DECRYPT_ITER_CBC_EN
  task automatic test_cbc;
    logic [63:0] got; int lat; logic b, r;
    iv = P_STD; iv_load = 1'b1; key = K_STD; ct = C_STD; in_valid = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL cbc_ivload_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    iv_load = 1'b0; in_valid = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL cbc_ivload_accepted: busy %b want 0", busy); end
    run_block(K_STD, C_STD, 1'b0, got, lat, b, r);
    tests_run++; if (got !== (P_STD ^ P_STD)) begin tests_failed++; $display("FAIL cbc_pt0: got %h want %h", got, P_STD ^ P_STD); end
    release_out();
    run_block(K_ZERO, C_ZERO, 1'b0, got, lat, b, r);
    tests_run++; if (got !== (P_ZERO ^ C_STD)) begin tests_failed++; $display("FAIL cbc_pt1: got %h want %h", got, P_ZERO ^ C_STD); end
    tests_run++; if (lat !== LAT) begin tests_failed++; $display("FAIL cbc_latency: got %0d want %0d", lat, LAT); end
    release_out();
  endtask
`endif

  initial begin
    test_reset();
    test_decrypt_zero();
    test_decrypt_vectors();
    test_hold_done();
    test_back_to_back();
    test_reset_mid();
`ifdef DES_DECRYPT_ITER_CBC_EN
    test_cbc();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
